// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deframes the serial stream and holds the last pressed make code (8'hFF = blank).
// Optional auto-repeat suppression is enabled with `define PS2_TYPEMATIC_FILTER_EN.
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       key_down,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall_d;
    logic                   parity_ok_d;

    state_t                 state_q;
    logic [3:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic                   par_q;
    logic                   stop_q;
    logic [TW-1:0]          to_cnt_q;
    logic                   done_q;
    logic                   ok_q;
    logic                   ext_q;
    logic                   brk_q;
    logic [7:0]             scancode_q;
    logic                   key_down_q;
    logic                   code_valid_q;
    logic                   frame_err_q;

    assign clk_s       = clk_sync_q[SYNC_STAGES-1];
    assign dat_s       = dat_sync_q[SYNC_STAGES-1];
    assign fall_d      = clk_prev_q & ~clk_s;
    assign parity_ok_d = stop_q & ((^shift_q) ^ par_q);

    // Synchronisers idle high so reset does not fabricate a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q <= clk_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            to_cnt_q     <= '0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            scancode_q   <= 8'hFF;
            key_down_q   <= 1'b0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            done_q       <= 1'b0;

            if (fall_d)
                to_cnt_q <= '0;
            else if (state_q == RECV)
                to_cnt_q <= to_cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (fall_d && !dat_s) begin
                        state_q   <= RECV;
                        bit_cnt_q <= '0;
                    end
                end
                RECV: begin
                    if (fall_d) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q < 4'd8) begin
                            shift_q <= {dat_s, shift_q[7:1]};
                        end else if (bit_cnt_q == 4'd8) begin
                            par_q <= dat_s;
                        end else begin
                            stop_q  <= dat_s;
                            state_q <= CHECK;
                        end
                    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end
                end
                CHECK: begin
                    done_q  <= 1'b1;
                    ok_q    <= parity_ok_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Interpret the completed byte; shift_q is stable until the next frame's first data edge.
            if (done_q) begin
                if (!ok_q) begin
                    frame_err_q <= 1'b1;
                    ext_q       <= 1'b0;
                    brk_q       <= 1'b0;
                end else if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (ext_q) begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end else if (brk_q) begin
                    brk_q <= 1'b0;
                    if (key_down_q && (shift_q == scancode_q)) begin
                        scancode_q   <= 8'hFF;
                        key_down_q   <= 1'b0;
                        code_valid_q <= 1'b1;
                    end
                end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (!(key_down_q && (shift_q == scancode_q))) begin
                        scancode_q   <= shift_q;
                        key_down_q   <= 1'b1;
                        code_valid_q <= 1'b1;
                    end
`else
                    scancode_q   <= shift_q;
                    key_down_q   <= 1'b1;
                    code_valid_q <= 1'b1;
`endif
                end
            end
        end
    end

    assign scancode   = scancode_q;
    assign key_down   = key_down_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: framed key sequences, error frames, timeout and reset.
module tb_ps2_scancode_rx;

    localparam int TIMEOUT = 10000;
    localparam int SYNC    = 2;
    localparam int H       = 20;  // clk cycles per ps2_clk half period

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       code_valid;
    logic       key_down;
    logic       frame_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cv_cnt   = 0;
    int fe_cnt   = 0;
    int cv_base;
    int fe_base;
    int lat;

    ps2_scancode_rx #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scancode  (scancode),
        .code_valid(code_valid),
        .key_down  (key_down),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) cv_cnt <= cv_cnt + 1;
        if (frame_err)  fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Sends the low nbits of bits (bit 0 first); lat = cycles from last falling edge to code_valid.
    task automatic send_bits(input logic [10:0] bits, input int nbits, output int lat_o);
        lat_o = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            for (int c = 1; c <= H; c++) begin
                @(negedge clk);
                if (lat_o < 0 && code_valid && i == nbits - 1) lat_o = c;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_code(input logic [7:0] code, input logic bad_par);
        logic par;
        int   l;
        par = ~(^code) ^ bad_par;
        send_bits({1'b1, par, code, 1'b0}, 11, l);
        lat = l;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scancode", scancode, 8'hFF);
        check("rst_key_down", key_down, 1'b0);
        check("rst_code_valid", code_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single make code with latency measurement
        cv_base = cv_cnt; fe_base = fe_cnt;
        send_code(8'h1C, 1'b0);
        check("make_scancode", scancode, 8'h1C);
        check("make_key_down", key_down, 1'b1);
        check("make_cv_pulses", cv_cnt - cv_base, 1);
        check("make_no_err", fe_cnt - fe_base, 0);
        check("make_latency", lat, SYNC + 3);

        // Matching release
        send_code(8'hF0, 1'b0);
        send_code(8'h1C, 1'b0);
        check("rel_scancode", scancode, 8'hFF);
        check("rel_key_down", key_down, 1'b0);
        check("rel_cv_pulses", cv_cnt - cv_base, 2);
        send_code(8'h32, 1'b0);
        check("make32_scancode", scancode, 8'h32);
        check("make32_key_down", key_down, 1'b1);

        // Mismatched release
        send_code(8'h1C, 1'b0);
        cv_base = cv_cnt;
        send_code(8'hF0, 1'b0);
        send_code(8'h32, 1'b0);
        check("mis_scancode", scancode, 8'h1C);
        check("mis_key_down", key_down, 1'b1);
        check("mis_cv_pulses", cv_cnt - cv_base, 0);

        // Parity error while blank
        send_code(8'hF0, 1'b0);
        send_code(8'h1C, 1'b0);
        check("blank_before_par", scancode, 8'hFF);
        cv_base = cv_cnt; fe_base = fe_cnt;
        send_code(8'h1C, 1'b1);
        check("par_err_pulses", fe_cnt - fe_base, 1);
        check("par_scancode", scancode, 8'hFF);
        check("par_cv_pulses", cv_cnt - cv_base, 0);

        // Timeout: start bit plus four data bits, then idle
        fe_base = fe_cnt;
        send_bits(11'b000_0000_1010, 5, lat);
        repeat (TIMEOUT + 100) @(negedge clk);
        check("timeout_err", fe_cnt - fe_base, 1);
        send_code(8'h45, 1'b0);
        check("after_to_scancode", scancode, 8'h45);
        check("after_to_err", fe_cnt - fe_base, 1);

        // Extended prefix consumes the following code
        send_code(8'hF0, 1'b0);
        send_code(8'h45, 1'b0);
        cv_base = cv_cnt;
        send_code(8'hE0, 1'b0);
        send_code(8'h75, 1'b0);
        check("ext_scancode", scancode, 8'hFF);
        check("ext_key_down", key_down, 1'b0);
        check("ext_cv_pulses", cv_cnt - cv_base, 0);

        // Typematic repeat
        cv_base = cv_cnt;
        for (int k = 0; k < 3; k++) send_code(8'h1C, 1'b0);
        check("typ_scancode", scancode, 8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("typ_cv_pulses", cv_cnt - cv_base, 1);
`else
        check("typ_cv_pulses", cv_cnt - cv_base, 3);
`endif

        // Asynchronous reset in the middle of a frame
        send_bits(11'b000_0000_0110, 4, lat);
        ps2_clk = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("arst_scancode", scancode, 8'hFF);
        check("arst_key_down", key_down, 1'b0);
        check("arst_code_valid", code_valid, 1'b0);
        check("arst_frame_err", frame_err, 1'b0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        send_code(8'h32, 1'b0);
        check("post_rst_scancode", scancode, 8'h32);
        check("post_rst_key_down", key_down, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
